// File: rtl/msp430_mem_pkg.sv
// rtl/msp430_mem_pkg.sv - shared widths, ROM window bounds and owner-state type for the memory arbiter
package msp430_mem_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int STREAK_W = 4;

    localparam logic [ADDR_W-1:0] ROM_BOUND_L = 16'hC000;
    localparam logic [ADDR_W-1:0] ROM_BOUND_U = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_OWN = 2'd1,
        DM_OWN = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - winner select between IF and DM with a bounded DM streak
module mem_arb_prio
    import msp430_mem_pkg::*;
#(
    parameter int MAX_DM_STREAK = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    output logic if_win,
    output logic dm_win
);

    logic [STREAK_W-1:0] r_streak;
    logic                w_force_if;

    assign w_force_if = (r_streak == STREAK_W'(MAX_DM_STREAK));
    assign if_win     = if_req & (~dm_req | w_force_if);
    assign dm_win     = dm_req & ~if_win;

    // Streak only counts DM grants that actually made IF wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= '0;
        end else if (~if_req | if_win) begin
            r_streak <= '0;
        end else if (dm_win & ~w_force_if) begin
            r_streak <= r_streak + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares the 16-bit memory port between instruction fetch and data access
module mem_bus_arbiter
    import msp430_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BOUND_L       = ROM_BOUND_L,
    parameter logic [ADDR_W-1:0] BOUND_U       = ROM_BOUND_U,
    parameter int                MAX_DM_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rom_sel,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_rom_wr,
    output logic              err_misalign
);

    logic              w_if_win;
    logic              w_dm_win;
    logic              w_grant;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_dm_rd;

    owner_e            r_state;
    owner_e            w_state_nxt;
    logic              r_dm_rd;
    logic [ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_err_rom_wr;
    logic              r_err_misalign;

    mem_arb_prio #(
        .MAX_DM_STREAK(MAX_DM_STREAK)
    ) u_prio (
        .clk    (clk),
        .rst    (rst),
        .if_req (if_req),
        .dm_req (dm_req),
        .if_win (w_if_win),
        .dm_win (w_dm_win)
    );

    assign if_gnt  = w_if_win;
    assign dm_gnt  = w_dm_win;
    assign w_grant = w_if_win | w_dm_win;
    assign w_dm_rd = w_dm_win & ~dm_we;

    // With no grant the port keeps presenting the last granted address.
    assign w_sel_addr  = w_if_win ? if_addr : (w_dm_win ? dm_addr : r_last_addr);
    assign mem_addr    = {w_sel_addr[ADDR_W-1:1], 1'b0};
    assign mem_rom_sel = (mem_addr >= BOUND_L) && ({1'b0, mem_addr} <= {1'b0, BOUND_U});
    assign mem_we      = w_dm_win & dm_we & ~mem_rom_sel;
    assign mem_wdata   = dm_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (w_if_win) begin
            w_state_nxt = IF_OWN;
        end else if (w_dm_win) begin
            w_state_nxt = DM_OWN;
        end
    end

    // The owner state names who was granted last cycle, so it doubles as the response-valid source.
    always_comb begin
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        case (r_state)
            IF_OWN:  if_rvalid = 1'b1;
            DM_OWN:  dm_rvalid = r_dm_rd;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dm_rd        <= 1'b0;
            r_last_addr    <= '0;
            r_if_rdata     <= '0;
            r_dm_rdata     <= '0;
            r_err_rom_wr   <= 1'b0;
            r_err_misalign <= 1'b0;
        end else begin
            r_dm_rd        <= w_dm_rd;
            r_err_rom_wr   <= w_dm_win & dm_we & mem_rom_sel;
            r_err_misalign <= w_grant & w_sel_addr[0];
            if (w_grant) begin
                r_last_addr <= mem_addr;
            end
            if (w_if_win) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_dm_rd) begin
                r_dm_rdata <= mem_rdata;
            end
        end
    end

    assign if_rdata     = r_if_rdata;
    assign dm_rdata     = r_dm_rdata;
    assign err_rom_wr   = r_err_rom_wr;
    assign err_misalign = r_err_misalign;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized and directed checks of mem_bus_arbiter against a reference model
module tb_mem_bus_arbiter;
    import msp430_mem_pkg::*;

    localparam int MAXS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_gnt;
    logic [15:0] if_rdata;
    logic        if_rvalid;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic        dm_gnt;
    logic [15:0] dm_rdata;
    logic        dm_rvalid;
    logic [15:0] mem_addr;
    logic        mem_rom_sel;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        err_rom_wr;
    logic        err_misalign;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .BOUND_L(16'hC000),
        .BOUND_U(16'hFFFF),
        .MAX_DM_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
        .mem_addr(mem_addr), .mem_rom_sel(mem_rom_sel), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .err_rom_wr(err_rom_wr), .err_misalign(err_misalign)
    );

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        if (a == 16'h0200) return 16'h1234;
        return {a[7:0], a[15:8]} ^ 16'hA5C3;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int          m_streak;
    logic [15:0] m_last, m_if_rdata, m_dm_rdata;
    logic        m_if_rv, m_dm_rv, m_err_rom, m_err_mis;
    logic        g_if, g_dm, g_we, g_rom;
    logic [15:0] g_addr;

    task automatic model_reset();
        m_streak = 0; m_last = '0; m_if_rdata = '0; m_dm_rdata = '0;
        m_if_rv = 0; m_dm_rv = 0; m_err_rom = 0; m_err_mis = 0;
    endtask

    // Drive one cycle of requests, check the combinational grant/port, then the registered response.
    task automatic step(input logic ifr, input logic [15:0] ifa, input logic dr, input logic dwe,
                        input logic [15:0] da, input logic [15:0] dwd);
        logic        eif, edm, rom, we;
        logic [15:0] raw, al, rd;
        if_req = ifr; if_addr = ifa; dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
        #2;
        eif = ifr && (!dr || m_streak == MAXS);
        edm = dr && !eif;
        raw = eif ? ifa : (edm ? da : m_last);
        al  = {raw[15:1], 1'b0};
        rom = (al >= 16'hC000);
        we  = edm && dwe && !rom;
        rd  = mem_fn(al);
        check("if_gnt", if_gnt, eif);
        check("dm_gnt", dm_gnt, edm);
        check("mem_addr", mem_addr, al);
        check("mem_rom_sel", mem_rom_sel, rom);
        check("mem_we", mem_we, we);
        if (we) check("mem_wdata", mem_wdata, dwd);
        g_if = if_gnt; g_dm = dm_gnt; g_we = mem_we; g_rom = mem_rom_sel; g_addr = mem_addr;
        m_if_rv = eif;
        if (eif) m_if_rdata = rd;
        m_dm_rv = edm && !dwe;
        if (m_dm_rv) m_dm_rdata = rd;
        m_err_rom = edm && dwe && rom;
        m_err_mis = (eif || edm) && raw[0];
        if (eif || edm) m_last = al;
        if (!ifr || eif) m_streak = 0;
        else if (edm && m_streak < MAXS) m_streak++;
        @(posedge clk);
        #1;
        check("if_rvalid", if_rvalid, m_if_rv);
        check("if_rdata", if_rdata, m_if_rdata);
        check("dm_rvalid", dm_rvalid, m_dm_rv);
        check("dm_rdata", dm_rdata, m_dm_rdata);
        check("err_rom_wr", err_rom_wr, m_err_rom);
        check("err_misalign", err_misalign, m_err_mis);
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] b [6] = '{16'hBFFF, 16'hBFFE, 16'hC000, 16'hFFFF, 16'h0200, 16'hC001};
        if ($urandom_range(0, 3) == 0) return b[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [5:0] order;
        logic [3:0] order2;
        int         nif;

        model_reset();
        #12;
        check("rst_if_rvalid", if_rvalid, 1'b0);
        check("rst_dm_rvalid", dm_rvalid, 1'b0);
        check("rst_rdata", {if_rdata, dm_rdata}, 32'h0);
        check("rst_errs", {err_rom_wr, err_misalign}, 2'b00);
        check("rst_mem_we", mem_we, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
        check("rd0200_gnt", g_dm, 1'b1);
        check("rd0200_rdata", dm_rdata, 16'h1234);
        check("rd0200_rvalid", dm_rvalid, 1'b1);
        idle();
        check("rd0200_rvalid_once", dm_rvalid, 1'b0);

        // contended: expected DM,DM,DM,IF,DM,DM (bit i = DM won cycle i)
        order = 6'b110111;
        nif = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'hC100, 1'b1, 1'b0, 16'h0300, 16'h0);
            check($sformatf("contend_dm_%0d", i), g_dm, order[i]);
            check($sformatf("contend_if_%0d", i), g_if, !order[i]);
            nif += int'(if_rvalid);
        end
        check("contend_if_rvalid_count", nif, 1);
        idle();

        step(1'b0, 16'h0, 1'b1, 1'b1, 16'hC010, 16'hBEEF);
        check("romwr_gnt", g_dm, 1'b1);
        check("romwr_we", g_we, 1'b0);
        check("romwr_err", err_rom_wr, 1'b1);
        check("romwr_no_rvalid", dm_rvalid, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'hBFFE, 16'h5A5A);
        check("ramwr_we", g_we, 1'b1);
        check("ramwr_rom_sel", g_rom, 1'b0);
        check("ramwr_err", err_rom_wr, 1'b0);

        step(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'h0);
        check("ffff_addr", g_addr, 16'hFFFE);
        check("ffff_rom_sel", g_rom, 1'b1);
        check("ffff_misalign", err_misalign, 1'b1);
        check("ffff_rvalid", if_rvalid, 1'b1);

        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0400, 16'h0);
        rst = 1'b1;
        #1;
        check("midrst_rvalid", {if_rvalid, dm_rvalid}, 2'b00);
        check("midrst_rdata", {if_rdata, dm_rdata}, 32'h0);
        check("midrst_errs", {err_rom_wr, err_misalign}, 2'b00);
        if_req = 0; dm_req = 0; dm_we = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle();
        check("postrst_rvalid", {if_rvalid, dm_rvalid}, 2'b00);

        step(1'b1, 16'hC200, 1'b1, 1'b0, 16'h0500, 16'h0);
        step(1'b1, 16'hC200, 1'b1, 1'b0, 16'h0500, 16'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0500, 16'h0);
        check("drop_dm", g_dm, 1'b1);
        order2 = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'hC200, 1'b1, 1'b0, 16'h0502, 16'h0);
            check($sformatf("restart_dm_%0d", i), g_dm, order2[i]);
        end
        idle();

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
